// File: rtl/tick_timer_pkg.sv
// Shared constants for the programmable tick timer.
//   ST_IDLE / ST_RUN / ST_DONE : controller state encodings
//   MODE_PERIODIC / MODE_ONESHOT : values captured into the mode register
package tick_timer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/prog_tick_timer_mod_counter.sv
// Runtime-modulus counter: counts enabled cycles from 0 to modulus-1, then wraps.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   clr       : synchronous clear to 0 (overrides en)
//   en        : count enable
//   modulus   : current modulus (>= 1)
//   count     : current count value
//   wrap      : combinational, high when an enabled edge will wrap count to 0
module mod_counter #(
  parameter int NBITS = 8,
  parameter int MW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [MW-1:0]    modulus,
  output logic [NBITS-1:0] count,
  output logic             wrap
);

  logic [NBITS-1:0] count_reg;
  logic [MW-1:0]    last_value;

  // count < modulus <= MAX always holds, so the zero-extended compare
  // at MW width never overflows.
  assign last_value = modulus - MW'(1);
  assign wrap       = en && (MW'(count_reg) == last_value);
  assign count      = count_reg;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (en) begin
      if (wrap) count_reg <= '0;
      else      count_reg <= count_reg + NBITS'(1);
    end
  end

endmodule

// File: rtl/prog_tick_timer.sv
// Event-tick timer with loadable modulus, periodic/one-shot mode and start/stop.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   incr        : count event
//   load        : capture modulus_in / mode_in (only outside RUN)
//   modulus_in  : new modulus (0 keeps old value, > MAX_MODULUS clamps)
//   mode_in     : 0 periodic, 1 one-shot
//   start, stop : begin / abort counting
//   number      : current count
//   tick        : registered one-cycle wrap pulse
//   busy, done  : state decodes for RUN and DONE
module prog_tick_timer
  import tick_timer_pkg::*;
#(
  parameter int MAX_MODULUS = 256,
  parameter int NBITS       = (MAX_MODULUS > 1) ? $clog2(MAX_MODULUS) : 1,
  parameter int MW          = $clog2(MAX_MODULUS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             incr,
  input  logic             load,
  input  logic [MW-1:0]    modulus_in,
  input  logic             mode_in,
  input  logic             start,
  input  logic             stop,
  output logic [NBITS-1:0] number,
  output logic             tick,
  output logic             busy,
  output logic             done
);

  localparam logic [MW-1:0] MOD_MAX = MW'(MAX_MODULUS);

  logic [1:0]    state_reg, state_next;
  logic [MW-1:0] mod_reg, mod_next;
  logic          mode_reg, mode_next;
  logic          tick_reg;
  logic [MW-1:0] mod_clamped;
  logic          in_run;
  logic          cnt_clr, cnt_en, cnt_wrap;

  assign in_run = (state_reg == ST_RUN);

  // Zero is not a usable modulus, so it leaves the current one in place.
  always_comb begin
    mod_clamped = modulus_in;
    if (modulus_in == '0)          mod_clamped = mod_reg;
    else if (modulus_in > MOD_MAX) mod_clamped = MOD_MAX;
  end

  // Outside RUN, load and start both restart the count from 0; in RUN,
  // stop clears it and also masks incr so no wrap can occur that edge.
  assign cnt_clr = in_run ? stop : (load || start);
  assign cnt_en  = in_run && !stop && incr;

  always_comb begin
    state_next = state_reg;
    mod_next   = mod_reg;
    mode_next  = mode_reg;
    case (state_reg)
      ST_RUN: begin
        if (stop)
          state_next = ST_IDLE;
        else if (cnt_wrap && (mode_reg == MODE_ONESHOT))
          state_next = ST_DONE;
      end
      ST_IDLE, ST_DONE: begin
        if (load) begin
          mod_next   = mod_clamped;
          mode_next  = mode_in;
          state_next = ST_IDLE;
        end
        // start wins over the load-induced return to IDLE; the freshly
        // loaded modulus/mode are what the new run uses.
        if (start) state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      mod_reg   <= MOD_MAX;
      mode_reg  <= MODE_PERIODIC;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      mod_reg   <= mod_next;
      mode_reg  <= mode_next;
      tick_reg  <= cnt_wrap;
    end
  end

  mod_counter #(
    .NBITS (NBITS),
    .MW    (MW)
  ) u_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .modulus (mod_reg),
    .count   (number),
    .wrap    (cnt_wrap)
  );

  assign tick = tick_reg;
  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);

endmodule

// File: tb/tb_prog_tick_timer.sv
// Directed bench for prog_tick_timer: each driven cycle pushes the expected
// outputs (from a small behavioural model) onto a queue, which is popped and
// compared 1 time unit after the sampling edge. Phase-level directed checks
// (tick counts, final values) are added with fixed constants.
module tb_prog_tick_timer;

  localparam int MAX = 256;
  localparam int NB  = 8;
  localparam int MW  = 9;

  logic          clk = 1'b0;
  logic          rst, incr, load, mode_in, start, stop;
  logic [MW-1:0] modulus_in;
  logic [NB-1:0] number;
  logic          tick, busy, done;

  always #5 clk = ~clk;

  prog_tick_timer #(.MAX_MODULUS(MAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .incr       (incr),
    .load       (load),
    .modulus_in (modulus_in),
    .mode_in    (mode_in),
    .start      (start),
    .stop       (stop),
    .number     (number),
    .tick       (tick),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [NB-1:0] number;
    logic          tick;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   tick_seen = 0;

  // Behavioural model: 0 idle, 1 run, 2 done
  int m_state = 0, m_num = 0, m_mod = MAX, m_mode = 0;
  bit m_tick = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_step();
    int mv;
    if (rst) begin
      m_state = 0; m_num = 0; m_mod = MAX; m_mode = 0; m_tick = 0;
      return;
    end
    m_tick = 0;
    if (m_state == 1) begin
      if (stop) begin
        m_state = 0; m_num = 0;
      end else if (incr) begin
        if (m_num == m_mod - 1) begin
          m_num = 0; m_tick = 1;
          if (m_mode == 1) m_state = 2;
        end else begin
          m_num = m_num + 1;
        end
      end
    end else begin
      if (load) begin
        mv = int'(modulus_in);
        if (mv > MAX)     m_mod = MAX;
        else if (mv != 0) m_mod = mv;
        m_mode = int'(mode_in); m_num = 0; m_state = 0;
      end
      if (start) begin
        m_state = 1; m_num = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, predict, then check after the edge.
  task automatic cyc(input bit r, input bit i, input bit l, input int mv,
                     input bit md, input bit s, input bit p);
    exp_t e, got;
    rst = r; incr = i; load = l; modulus_in = mv[MW-1:0];
    mode_in = md; start = s; stop = p;
    model_step();
    e.number = m_num[NB-1:0]; e.tick = m_tick;
    e.busy = (m_state == 1); e.done = (m_state == 2);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("number", int'(number), int'(got.number));
    chk("tick",   int'(tick),   int'(got.tick));
    chk("busy",   int'(busy),   int'(got.busy));
    chk("done",   int'(done),   int'(got.done));
    if (tick === 1'b1) tick_seen++;
    $display("[TB] t=%0t rst=%0b incr=%0b load=%0b mod_in=%0d mode=%0b start=%0b stop=%0b -> number=%0d tick=%0b busy=%0b done=%0b",
             $time, r, i, l, mv, md, s, p, number, tick, busy, done);
  endtask

  task automatic idle_cyc();       cyc(0, 0, 0, 0, 0, 0, 0); endtask
  task automatic inc_cyc();        cyc(0, 1, 0, 0, 0, 0, 0); endtask
  task automatic start_cyc();      cyc(0, 0, 0, 0, 0, 1, 0); endtask
  task automatic stop_cyc();       cyc(0, 0, 0, 0, 0, 0, 1); endtask
  task automatic load_cyc(input int mv, input bit md); cyc(0, 0, 1, mv, md, 0, 0); endtask

  initial begin
    rst = 1; incr = 0; load = 0; modulus_in = '0; mode_in = 0; start = 0; stop = 0;

    // Reset, then incr in IDLE is ignored
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("reset_number", int'(number), 0);
    chk("reset_tick",   int'(tick), 0);
    tick_seen = 0;
    for (int k = 0; k < 300; k++) inc_cyc();
    chk("idle_ticks", tick_seen, 0);
    chk("idle_number", int'(number), 0);
    chk("idle_busy", int'(busy), 0);

    // Periodic modulus 5, 12 incr -> ticks after #5 and #10, number 2
    load_cyc(5, 0);
    start_cyc();
    tick_seen = 0;
    for (int k = 1; k <= 12; k++) begin
      inc_cyc();
      chk("per5_tick_pos", int'(tick), (k == 5 || k == 10) ? 1 : 0);
    end
    chk("per5_ticks", tick_seen, 2);
    chk("per5_number", int'(number), 2);
    chk("per5_busy", int'(busy), 1);
    stop_cyc();

    // One-shot modulus 3, 5 incr -> single tick, then DONE
    load_cyc(3, 1);
    start_cyc();
    tick_seen = 0;
    for (int k = 0; k < 5; k++) inc_cyc();
    chk("os3_ticks", tick_seen, 1);
    chk("os3_done", int'(done), 1);
    chk("os3_busy", int'(busy), 0);
    chk("os3_number", int'(number), 0);

    // stop + incr together at number 2, then load in RUN is ignored
    load_cyc(4, 0);
    start_cyc();
    inc_cyc(); inc_cyc();
    chk("pre_stop_number", int'(number), 2);
    cyc(0, 1, 0, 0, 0, 0, 1);
    chk("stop_number", int'(number), 0);
    chk("stop_busy", int'(busy), 0);
    chk("stop_tick", int'(tick), 0);
    start_cyc();
    load_cyc(7, 0);
    tick_seen = 0;
    for (int k = 0; k < 4; k++) inc_cyc();
    chk("run_load_ignored", tick_seen, 1);
    chk("run_load_tick4", int'(tick), 1);
    stop_cyc();

    // modulus 0 keeps 4
    load_cyc(0, 0);
    start_cyc();
    tick_seen = 0;
    for (int k = 0; k < 4; k++) inc_cyc();
    chk("mod0_keeps", tick_seen, 1);
    stop_cyc();

    // 1000 truncates to a 9-bit value above 256, clamps to 256
    load_cyc(1000, 0);
    start_cyc();
    tick_seen = 0;
    for (int k = 0; k < 255; k++) inc_cyc();
    chk("clamp_no_early_tick", tick_seen, 0);
    inc_cyc();
    chk("clamp_ticks", tick_seen, 1);
    stop_cyc();

    // modulus 1: tick on every incr cycle
    load_cyc(1, 0);
    start_cyc();
    tick_seen = 0;
    for (int k = 0; k < 5; k++) inc_cyc();
    chk("mod1_ticks", tick_seen, 5);
    chk("mod1_number", int'(number), 0);
    stop_cyc();

    // load 6 and start in the same cycle
    cyc(0, 0, 1, 6, 0, 1, 0);
    chk("ldst_busy", int'(busy), 1);
    tick_seen = 0;
    for (int k = 0; k < 5; k++) inc_cyc();
    chk("ldst_no_tick5", tick_seen, 0);
    inc_cyc();
    chk("ldst_tick6", tick_seen, 1);

    // reset mid-run at number 4
    for (int k = 0; k < 4; k++) inc_cyc();
    chk("pre_rst_number", int'(number), 4);
    cyc(1, 1, 0, 0, 0, 0, 0);
    chk("rst_number", int'(number), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tick", int'(tick), 0);
    idle_cyc();

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
